// File: rtl/io_share_pkg.sv
// Shared constants and types for the GPIO pad-sharing controller.
package io_share_pkg;

  localparam int SELW = 3;

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_ANA_LO = 8'h04;
  localparam logic [7:0] OFS_ANA_HI = 8'h08;
  localparam logic [7:0] OFS_STATUS = 8'h0C;

  localparam int STAT_SEL_LSB = 0;
  localparam int STAT_BUSY    = 8;
  localparam int STAT_ERR     = 9;
  localparam int STAT_LAOVR   = 10;
  localparam int STAT_CNT_LSB = 16;

  typedef enum logic [1:0] {
    ACTIVE,
    QUIESCE,
    COMMIT
  } state_e;

endpackage

// File: rtl/io_share_ctrl_if.sv
// Wishbone slave bundle for the pad-sharing controller.
interface io_share_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/io_share_wb_regs.sv
// Wishbone decode, single-cycle ack, analog mask, CTRL request strobe and STATUS.
module io_share_wb_regs
  import io_share_pkg::*;
#(
  parameter int              N_PADS       = 38,
  parameter logic [31:0]     BASE_ADDR    = 32'h3000_0000,
  parameter logic [N_PADS-1:0] ANA_MASK_RST = {N_PADS{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  io_share_ctrl_if.slave    wb,
  input  logic [SELW-1:0]   active_sel,
  input  logic [SELW-1:0]   pending,
  input  logic              busy,
  input  logic [7:0]        cnt,
  input  logic              la_ovr,
  input  logic              err_set,
  output logic [N_PADS-1:0] mask,
  output logic              ctrl_wr,
  output logic [SELW-1:0]   ctrl_sel
);

  logic        hit;
  logic        req;
  logic        wr_acc;
  logic [7:0]  ofs;
  logic        lo_wr;
  logic        hi_wr;
  logic        err;
  logic        err_clr;
  logic [31:0] mask_lo;
  logic [31:0] mask_hi;
  logic [31:0] rdata;

  assign hit = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~wb.wbs_ack_o;
  assign ofs = wb.wbs_adr_i[7:0];

  // Writes land on the ack cycle while the master still holds address and data.
  assign wr_acc   = wb.wbs_ack_o & wb.wbs_stb_i & wb.wbs_cyc_i & wb.wbs_we_i;
  assign lo_wr    = wr_acc && (ofs == OFS_ANA_LO);
  assign hi_wr    = wr_acc && (ofs == OFS_ANA_HI);
  assign ctrl_wr  = wr_acc && (ofs == OFS_CTRL) && wb.wbs_sel_i[0];
  assign ctrl_sel = wb.wbs_dat_i[SELW-1:0];
  assign err_clr  = wr_acc && (ofs == OFS_STATUS) && wb.wbs_sel_i[1] && wb.wbs_dat_i[STAT_ERR];

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= ANA_MASK_RST;
    end else begin
      for (int p = 0; p < N_PADS; p++) begin
        if (((p < 32) ? lo_wr : hi_wr) && wb.wbs_sel_i[p[4:3]])
          mask[p] <= wb.wbs_dat_i[p[4:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  always_comb begin
    mask_lo = '0;
    mask_hi = '0;
    for (int p = 0; p < N_PADS; p++) begin
      if (p < 32) mask_lo[p[4:0]] = mask[p];
      else        mask_hi[p[4:0]] = mask[p];
    end
    rdata = '0;
    case (ofs)
      OFS_CTRL:   rdata[SELW-1:0] = pending;
      OFS_ANA_LO: rdata = mask_lo;
      OFS_ANA_HI: rdata = mask_hi;
      OFS_STATUS: begin
        rdata[STAT_SEL_LSB +: SELW] = active_sel;
        rdata[STAT_BUSY]            = busy;
        rdata[STAT_ERR]             = err;
        rdata[STAT_LAOVR]           = la_ovr;
        rdata[STAT_CNT_LSB +: 8]    = cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : '0;
    end
  end

endmodule

// File: rtl/io_share_ctrl.sv
// Pad-sharing controller: switch FSM with timed quiesce window and pad mux.
// Optional IO_SHARE_LA_OVERRIDE_EN adds a logic-analyser driven select request.
module io_share_ctrl
  import io_share_pkg::*;
#(
  parameter int                N_DESIGNS    = 4,
  parameter int                N_PADS       = 38,
  parameter logic [31:0]       BASE_ADDR    = 32'h3000_0000,
  parameter int                GUARD_CYCLES = 8,
  parameter logic [N_PADS-1:0] ANA_MASK_RST = {N_PADS{1'b0}}
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  io_share_ctrl_if.slave                wb,
`ifdef IO_SHARE_LA_OVERRIDE_EN
  input  logic                          la_ovr_en_i,
  input  logic [SELW-1:0]               la_ovr_sel_i,
`endif
  input  logic [N_PADS-1:0]             io_in,
  output logic [N_PADS-1:0]             io_out,
  output logic [N_PADS-1:0]             io_oeb,
  input  logic [N_DESIGNS*N_PADS-1:0]   dsn_io_out,
  input  logic [N_DESIGNS*N_PADS-1:0]   dsn_io_oeb,
  output logic [N_DESIGNS*N_PADS-1:0]   dsn_io_in,
  output logic [N_DESIGNS-1:0]          dsn_rst_o,
  output logic                          sw_irq_o
);

  localparam logic [SELW:0] NDES  = (SELW+1)'(N_DESIGNS);
  localparam logic [7:0]    GUARD = 8'(GUARD_CYCLES);

  state_e              state, state_n;
  logic [7:0]          cnt, cnt_n;
  logic [SELW-1:0]     active_sel, active_n;
  logic [SELW-1:0]     pending, pending_n;
  logic [N_PADS-1:0]   mask;
  logic                ctrl_wr;
  logic [SELW-1:0]     ctrl_sel;
  logic                req;
  logic [SELW-1:0]     req_sel;
  logic                req_ok;
  logic                err_set;
  logic                la_ovr;
  logic                busy;

`ifdef IO_SHARE_LA_OVERRIDE_EN
  assign la_ovr  = la_ovr_en_i;
  assign req     = la_ovr_en_i ? (state == ACTIVE) : ctrl_wr;
  assign req_sel = la_ovr_en_i ? la_ovr_sel_i : ctrl_sel;
`else
  assign la_ovr  = 1'b0;
  assign req     = ctrl_wr;
  assign req_sel = ctrl_sel;
`endif

  assign req_ok  = req && ({1'b0, req_sel} < NDES);
  assign err_set = req && !req_ok;
  assign busy    = (state != ACTIVE);

  io_share_wb_regs #(
    .N_PADS       (N_PADS),
    .BASE_ADDR    (BASE_ADDR),
    .ANA_MASK_RST (ANA_MASK_RST)
  ) u_regs (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .wb         (wb),
    .active_sel (active_sel),
    .pending    (pending),
    .busy       (busy),
    .cnt        (cnt),
    .la_ovr     (la_ovr),
    .err_set    (err_set),
    .mask       (mask),
    .ctrl_wr    (ctrl_wr),
    .ctrl_sel   (ctrl_sel)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= QUIESCE;
      cnt        <= GUARD;
      active_sel <= '0;
      pending    <= '0;
      sw_irq_o   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_sel <= active_n;
      pending    <= pending_n;
      sw_irq_o   <= (state == COMMIT);
    end
  end

  // A request landing in COMMIT itself is honoured rather than lost.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    active_n  = active_sel;
    pending_n = pending;
    case (state)
      ACTIVE: begin
        if (req_ok && (req_sel != active_sel)) begin
          pending_n = req_sel;
          cnt_n     = GUARD;
          state_n   = QUIESCE;
        end
      end
      QUIESCE: begin
        if (req_ok) pending_n = req_sel;
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) state_n = COMMIT;
      end
      COMMIT: begin
        if (req_ok) pending_n = req_sel;
        active_n = pending_n;
        state_n  = ACTIVE;
      end
      default: state_n = QUIESCE;
    endcase
  end

  always_comb begin
    io_out    = '0;
    io_oeb    = '1;
    dsn_io_in = '0;
    dsn_rst_o = '1;
    if (state == ACTIVE) begin
      for (int d = 0; d < N_DESIGNS; d++) begin
        if (active_sel == SELW'(d)) begin
          io_out                     = dsn_io_out[d*N_PADS +: N_PADS];
          io_oeb                     = dsn_io_oeb[d*N_PADS +: N_PADS];
          dsn_io_in[d*N_PADS +: N_PADS] = io_in;
          dsn_rst_o[d]               = 1'b0;
        end
      end
    end
    io_out = io_out & ~mask;
    io_oeb = io_oeb | mask;
  end

endmodule

// File: tb/tb_io_share_ctrl.sv
// Randomized bench for io_share_ctrl against a cycle-timeline reference model.
module tb_io_share_ctrl;

  localparam int          ND   = 4;
  localparam int          NP   = 38;
  localparam int          GC   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_share_ctrl_if wb ();

  logic [NP-1:0]    io_in, io_out, io_oeb;
  logic [ND*NP-1:0] dsn_io_out, dsn_io_oeb, dsn_io_in;
  logic [ND-1:0]    dsn_rst;
  logic             sw_irq;

  io_share_ctrl #(
    .N_DESIGNS    (ND),
    .N_PADS       (NP),
    .BASE_ADDR    (BASE),
    .GUARD_CYCLES (GC),
    .ANA_MASK_RST ({NP{1'b0}})
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
`ifdef IO_SHARE_LA_OVERRIDE_EN
    .la_ovr_en_i  (1'b0),
    .la_ovr_sel_i (3'd0),
`endif
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .dsn_io_out (dsn_io_out),
    .dsn_io_oeb (dsn_io_oeb),
    .dsn_io_in  (dsn_io_in),
    .dsn_rst_o  (dsn_rst),
    .sw_irq_o   (sw_irq)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: m_left counts the cycles remaining in a switch window
  // (guard cycles plus the commit cycle); zero means a design owns the pads.
  int          m_act, m_pend, m_left;
  logic [NP-1:0] m_mask;
  bit          m_err, m_irq, m_ack;
  logic [31:0] m_dat;
  logic [31:0] obs_dat;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] model_read(input logic [7:0] ofs);
    logic [31:0] v;
    v = '0;
    case (ofs)
      8'h00: v = 32'(m_pend);
      8'h04: v = m_mask[31:0];
      8'h08: v = 32'(m_mask[NP-1:32]);
      8'h0C: begin
        v[2:0]   = 3'(m_act);
        v[8]     = (m_left > 0);
        v[9]     = m_err;
        v[23:16] = (m_left > 0) ? 8'(m_left - 1) : 8'd0;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check_outputs();
    logic [NP-1:0]    e_out, e_oeb;
    logic [ND*NP-1:0] e_in;
    logic [ND-1:0]    e_rst;
    e_in  = '0;
    e_rst = '1;
    if (m_left == 0) begin
      e_out = dsn_io_out[m_act*NP +: NP];
      e_oeb = dsn_io_oeb[m_act*NP +: NP];
      e_in[m_act*NP +: NP] = io_in;
      e_rst[m_act] = 1'b0;
    end else begin
      e_out = '0;
      e_oeb = '1;
    end
    e_out = e_out & ~m_mask;
    e_oeb = e_oeb | m_mask;
    check("io_out", io_out, e_out);
    check("io_oeb", io_oeb, e_oeb);
    check("dsn_io_in", dsn_io_in, e_in);
    check("dsn_rst", dsn_rst, e_rst);
    check("sw_irq", sw_irq, m_irq);
    check("ack", wb.wbs_ack_o, m_ack);
    check("dat_o", wb.wbs_dat_o, m_dat);
  endtask

  task automatic cycle();
    logic [159:0] r1, r2;
    logic [63:0]  r3;
    logic [7:0]   ofs;
    bit           hit, bus, wr;
    int           rsel;
    int           n_act, n_pend, n_left;
    logic [NP-1:0] n_mask;
    bit           n_err, n_irq, n_ack;
    logic [31:0]  n_dat;
    for (int w = 0; w < 5; w++) begin
      r1[w*32 +: 32] = $urandom;
      r2[w*32 +: 32] = $urandom;
    end
    r3 = {$urandom, $urandom};
    dsn_io_out = r1[ND*NP-1:0];
    dsn_io_oeb = r2[ND*NP-1:0];
    io_in      = r3[NP-1:0];
    #1;
    if (chk_en) check_outputs();
    obs_dat = wb.wbs_dat_o;

    ofs = wb.wbs_adr_i[7:0];
    hit = (wb.wbs_adr_i[31:8] == BASE[31:8]);
    bus = wb.wbs_stb_i && wb.wbs_cyc_i;
    wr  = m_ack && bus && wb.wbs_we_i;
    n_ack  = bus && hit && !m_ack;
    n_dat  = (n_ack && !wb.wbs_we_i) ? model_read(ofs) : 32'd0;
    n_act  = m_act;
    n_pend = m_pend;
    n_err  = m_err;
    n_mask = m_mask;
    n_left = (m_left > 0) ? m_left - 1 : 0;
    n_irq  = (m_left == 1);
    if (wr && ofs == 8'h04)
      for (int p = 0; p < 32; p++) if (wb.wbs_sel_i[p/8]) n_mask[p] = wb.wbs_dat_i[p];
    if (wr && ofs == 8'h08)
      for (int p = 32; p < NP; p++) if (wb.wbs_sel_i[(p-32)/8]) n_mask[p] = wb.wbs_dat_i[p-32];
    if (wr && ofs == 8'h0C && wb.wbs_sel_i[1] && wb.wbs_dat_i[9]) n_err = 1'b0;
    if (wr && ofs == 8'h00 && wb.wbs_sel_i[0]) begin
      rsel = int'(wb.wbs_dat_i[2:0]);
      if (rsel >= ND) n_err = 1'b1;
      else if (m_left == 0) begin
        if (rsel != m_act) begin
          n_pend = rsel;
          n_left = GC + 1;
        end
      end else n_pend = rsel;
    end
    if (m_left == 1) n_act = n_pend;
    if (rst) begin
      n_act = 0; n_pend = 0; n_left = GC + 1; n_mask = '0;
      n_err = 1'b0; n_irq = 1'b0; n_ack = 1'b0; n_dat = '0;
    end
    @(posedge clk);
    m_act = n_act; m_pend = n_pend; m_left = n_left; m_mask = n_mask;
    m_err = n_err; m_irq = n_irq; m_ack = n_ack; m_dat = n_dat;
    #1;
  endtask

  task automatic bus_idle();
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_sel_i = sel;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    cycle();
    cycle();
    bus_idle();
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = '0;
    cycle();
    cycle();
    dat = obs_dat;
    bus_idle();
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  ofs_tab [5];
    ofs_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20};
    bus_idle();
    m_act = 0; m_pend = 0; m_left = GC + 1; m_mask = '0;
    m_err = 1'b0; m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    // Start-up quiesce, then design 0 owns the pads.
    repeat (GC + 2) cycle();
    wb_read(BASE + 32'h0C, rd);
    check("status_after_boot", rd, 32'h0000_0000);
    check("dsn_rst_boot", dsn_rst, 4'b1110);

    wb_write(BASE + 32'h00, 32'd2, 4'hF);
    repeat (GC + 3) cycle();
    check("dsn_rst_sel2", dsn_rst, 4'b1011);
    wb_read(BASE + 32'h0C, rd);
    check("status_sel2", rd, 32'h0000_0002);

    wb_write(BASE + 32'h00, 32'd5, 4'hF);
    wb_read(BASE + 32'h0C, rd);
    check("status_err", rd, 32'h0000_0202);
    wb_write(BASE + 32'h0C, 32'h0000_0200, 4'hF);
    wb_read(BASE + 32'h0C, rd);
    check("status_err_clr", rd, 32'h0000_0002);

    wb_write(BASE + 32'h00, 32'd1, 4'hF);
    repeat (GC + 3) cycle();
    wb_write(BASE + 32'h04, 32'h0003_F000, 4'hF);
    cycle();
    check("ana_oeb_12_17", io_oeb[17:12], 6'h3F);
    check("ana_out_12_17", io_out[17:12], 6'h00);
    wb_read(BASE + 32'h04, rd);
    check("ana_lo_rd", rd, 32'h0003_F000);

    // Retarget mid-quiesce; the window must not restart.
    wb_write(BASE + 32'h00, 32'd2, 4'hF);
    repeat (3) cycle();
    wb_write(BASE + 32'h00, 32'd3, 4'hF);
    repeat (GC) cycle();
    wb_read(BASE + 32'h0C, rd);
    check("status_retarget", rd, 32'h0000_0003);

    wb_write(BASE + 32'h00, 32'd0, 4'hF);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wb_read(BASE + 32'h0C, rd);
    check("status_post_rst", rd, 32'h0008_0100);
    wb_read(BASE + 32'h20, rd);
    check("unmapped_rd", rd, 32'h0000_0000);
    repeat (GC + 2) cycle();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cycle();
        4, 5: wb_write(BASE | 32'(ofs_tab[$urandom_range(0, 4)]), $urandom, 4'($urandom_range(0, 15)));
        6: wb_read(BASE | 32'(ofs_tab[$urandom_range(0, 4)]), rd);
        7: wb_write(BASE, 32'($urandom_range(0, 7)), 4'hF);
        8: begin
          wb.wbs_stb_i = 1'b1;
          wb.wbs_cyc_i = 1'b1;
          wb.wbs_we_i  = 1'($urandom_range(0, 1));
          wb.wbs_sel_i = 4'hF;
          wb.wbs_adr_i = ($urandom_range(0, 1) == 0) ? 32'h3000_0100 : 32'h2000_000C;
          wb.wbs_dat_i = $urandom;
          cycle();
          cycle();
          bus_idle();
        end
        default: begin
          if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
          end else cycle();
        end
      endcase
    end
    repeat (GC + 3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
